crc32_frame_checker: RTL and testbench

//  Receive-side CRC-32 checker; counterpart of the team's CRC-32 generator. Accepts a byte stream holding

---
 rtl/crc32_pkg.sv | 26 ++
 rtl/crc32_serial_step.sv | 26 ++
 rtl/crc32_frame_checker.sv | 131 +++++++++++++
 tb/tb_crc32_frame_checker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/crc32_pkg.sv
// rtl/crc32_pkg.sv - shared constants and FSM encodings for the CRC-32 frame checker
//
// Purpose: default CRC geometry, generator polynomial, minimum legal frame
// length, checker state encodings and the statistics counter width.
// Ports: none (package).
package crc32_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int CRC_WIDTH_DEF  = 32;
    localparam int LEN_WIDTH_DEF  = 16;

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

    // FCS beats carried at the end of every frame
    localparam int CRC_BYTES = CRC_WIDTH_DEF / DATA_WIDTH_DEF;

    // Shortest frame that still holds at least one payload beat
    localparam int MIN_FRAME_BEATS = CRC_BYTES + 1;

    localparam int STATS_WIDTH = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

endpackage

// File: rtl/crc32_serial_step.sv
// rtl/crc32_serial_step.sv - combinational one-bit CRC LFSR update
//
// Purpose: advances the CRC register by one message bit (MSB-first,
// non-reflected). The generator uses the same block so both ends agree
// bit for bit.
// Ports:
//   crc_in   in   CRC_WIDTH  current remainder
//   bit_in   in   1          next message bit
//   crc_out  out  CRC_WIDTH  updated remainder
module crc32_serial_step
    import crc32_pkg::*;
#(
    parameter int                   CRC_WIDTH = CRC_WIDTH_DEF,
    parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(CRC_POLY)
) (
    input  logic [CRC_WIDTH-1:0] crc_in,
    input  logic                 bit_in,
    output logic [CRC_WIDTH-1:0] crc_out
);

    logic fb;

    assign fb      = crc_in[CRC_WIDTH-1] ^ bit_in;
    assign crc_out = {crc_in[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc32_frame_checker.sv
// rtl/crc32_frame_checker.sv - receive-side bit-serial CRC-32 frame checker
//
// Purpose: divides payload plus trailing FCS (MSB first) by POLY with init 0,
// no reflection and no final XOR; a zero residue on a long-enough frame is a
// good frame. One input bit is consumed per clock.
// Optional feature macro: CRC_CHK_STATS_EN adds good_cnt / bad_cnt.
// Ports:
//   clk          in   1           rising-edge clock
//   rst          in   1           synchronous active-high reset
//   in_valid     in   1           in_data / in_last valid
//   in_ready     out  1           beat accepted (IDLE only)
//   in_data      in   DATA_WIDTH  payload or FCS beat
//   in_last      in   1           final FCS beat of the frame
//   out_valid    out  1           one-cycle verdict strobe
//   out_crc_ok   out  1           residue zero and length legal
//   out_len_err  out  1           frame shorter than CRC_BYTES+1 beats
//   out_residue  out  CRC_WIDTH   final remainder
//   good_cnt     out  16          saturating good-verdict count (CRC_CHK_STATS_EN)
//   bad_cnt      out  16          saturating bad-verdict count (CRC_CHK_STATS_EN)
module crc32_frame_checker
    import crc32_pkg::*;
#(
    parameter int                   DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int                   CRC_WIDTH  = CRC_WIDTH_DEF,
    parameter logic [CRC_WIDTH-1:0] POLY       = CRC_WIDTH'(CRC_POLY),
    parameter int                   LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    output logic                   out_crc_ok,
    output logic                   out_len_err,
    output logic [CRC_WIDTH-1:0]   out_residue
`ifdef CRC_CHK_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] good_cnt,
    output logic [STATS_WIDTH-1:0] bad_cnt
`endif
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [LEN_WIDTH-1:0] MIN_BEATS = LEN_WIDTH'(CRC_WIDTH / DATA_WIDTH + 1);

    logic [1:0]            state_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  last_q;
    logic [BIT_W-1:0]      bitcnt_q;
    logic [CRC_WIDTH-1:0]  crc_q;
    logic [CRC_WIDTH-1:0]  crc_next;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic                  len_err_w;
    logic                  ok_w;

    crc32_serial_step #(
        .CRC_WIDTH (CRC_WIDTH),
        .POLY      (POLY)
    ) u_step (
        .crc_in  (crc_q),
        .bit_in  (din_q[bitcnt_q]),
        .crc_out (crc_next)
    );

    // Gated by rst so the source never sees a handshake while the block is held
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign len_err_w = (cnt_q < MIN_BEATS);
    assign ok_w      = (crc_q == '0) && !len_err_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            din_q       <= '0;
            last_q      <= 1'b0;
            bitcnt_q    <= '0;
            crc_q       <= '0;
            cnt_q       <= '0;
            out_valid   <= 1'b0;
            out_crc_ok  <= 1'b0;
            out_len_err <= 1'b0;
            out_residue <= '0;
`ifdef CRC_CHK_STATS_EN
            good_cnt    <= '0;
            bad_cnt     <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        din_q    <= in_data;
                        last_q   <= in_last;
                        // Saturate rather than wrap so a huge frame never looks short
                        cnt_q    <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                        bitcnt_q <= BIT_W'(DATA_WIDTH - 1);
                        state_q  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    crc_q    <= crc_next;
                    bitcnt_q <= bitcnt_q - 1'b1;
                    if (bitcnt_q == '0) begin
                        state_q <= last_q ? ST_CHECK : ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    out_valid   <= 1'b1;
                    out_residue <= crc_q;
                    out_len_err <= len_err_w;
                    out_crc_ok  <= ok_w;
`ifdef CRC_CHK_STATS_EN
                    if (ok_w) begin
                        good_cnt <= (&good_cnt) ? good_cnt : good_cnt + 1'b1;
                    end else begin
                        bad_cnt  <= (&bad_cnt) ? bad_cnt : bad_cnt + 1'b1;
                    end
`endif
                    crc_q       <= '0;
                    cnt_q       <= '0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc32_frame_checker.sv
// tb/tb_crc32_frame_checker.sv - self-checking bench for crc32_frame_checker
module tb_crc32_frame_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_crc_ok;
    logic        out_len_err;
    logic [31:0] out_residue;
`ifdef CRC_CHK_STATS_EN
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;
`endif

    crc32_frame_checker dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_crc_ok  (out_crc_ok),
        .out_len_err (out_len_err),
        .out_residue (out_residue)
`ifdef CRC_CHK_STATS_EN
        ,
        .good_cnt    (good_cnt),
        .bad_cnt     (bad_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [103:0] frame;
        int           len;
        logic         ok;
        logic         le;
        logic [31:0]  res;
        bit           chk_res;
    } vec_t;

    vec_t tv [0:6];

    int n_cmp = 0;
    int n_bad = 0;
    int strobes = 0;
    int ok_strobes = 0;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            strobes = strobes + 1;
            if (out_crc_ok === 1'b1) ok_strobes = ok_strobes + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Sends the first nsend beats of a len-beat frame. first_waits counts the
    // negedges in_ready was low before beat 0; bad_mid counts later beats whose
    // stall differed from the 8-cycle shift.
    task automatic send_frame(input logic [103:0] fr, input int len, input int nsend,
                              input bit hold, output int first_waits, output int bad_mid);
        int waits;
        first_waits = 0;
        bad_mid     = 0;
        for (int i = 0; i < nsend; i++) begin
            in_valid = 1'b1;
            in_data  = fr[(len-1-i)*8 +: 8];
            in_last  = (i == len - 1);
            waits    = 0;
            while (1) begin
                @(negedge clk);
                if (in_ready === 1'b1) break;
                waits++;
                if (waits > 40) begin
                    n_cmp = n_cmp + 1;
                    n_bad = n_bad + 1;
                    $display("FAIL in_ready_timeout: got stall %0d, required <= 40", waits);
                    in_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
            if (i == 0) first_waits = waits;
            else if (waits != 8) bad_mid++;
        end
        if (!hold) in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_verdict(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                lat = i;
                return;
            end
        end
    endtask

    initial begin
        int fw, bm, lat, s0, o0;

        tv[0] = '{"zeros",      104'h00_00_00_00_00,                      5,  1'b1, 1'b0, 32'h0,        1'b1};
        tv[1] = '{"poly_good",  104'h01_04_C1_1D_B7,                      5,  1'b1, 1'b0, 32'h0,        1'b1};
        tv[2] = '{"poly_bad",   104'h01_04_C1_1D_B6,                      5,  1'b0, 1'b0, 32'h04C11DB7, 1'b1};
        tv[3] = '{"check_good", 104'h31_32_33_34_35_36_37_38_39_89_A1_89_7F, 13, 1'b1, 1'b0, 32'h0,     1'b1};
        tv[4] = '{"check_bad",  104'h31_32_33_34_35_36_37_38_39_89_A1_89_7E, 13, 1'b0, 1'b0, 32'h04C11DB7, 1'b1};
        tv[5] = '{"short3",     104'hAA_BB_CC,                            3,  1'b0, 1'b1, 32'h0,        1'b0};
        tv[6] = '{"short4_zero",104'h00_00_00_00,                         4,  1'b0, 1'b1, 32'h0,        1'b1};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",    {31'b0, in_ready},    32'd0);
        check("rst_out_valid",   {31'b0, out_valid},   32'd0);
        check("rst_out_crc_ok",  {31'b0, out_crc_ok},  32'd0);
        check("rst_out_len_err", {31'b0, out_len_err}, 32'd0);
        check("rst_out_residue", out_residue,          32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", {31'b0, in_ready}, 32'd1);

        for (int k = 0; k < 7; k++) begin
            s0 = strobes;
            send_frame(tv[k].frame, tv[k].len, tv[k].len, 1'b0, fw, bm);
            check({tv[k].name, "_beat_stall"}, bm, 0);
            wait_verdict(lat);
            check({tv[k].name, "_latency"}, lat, 9);
            check({tv[k].name, "_crc_ok"},  {31'b0, out_crc_ok},  {31'b0, tv[k].ok});
            check({tv[k].name, "_len_err"}, {31'b0, out_len_err}, {31'b0, tv[k].le});
            if (tv[k].chk_res) check({tv[k].name, "_residue"}, out_residue, tv[k].res);
            @(posedge clk);
            #1;
            check({tv[k].name, "_strobe_width"}, {31'b0, out_valid}, 32'd0);
            check({tv[k].name, "_strobe_count"}, strobes - s0, 1);
            check({tv[k].name, "_hold_ok"}, {31'b0, out_crc_ok}, {31'b0, tv[k].ok});
        end

        // Reset in the middle of shifting beat 3 discards the frame silently
        s0 = strobes;
        send_frame(tv[3].frame, tv[3].len, 3, 1'b0, fw, bm);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("midrst_no_strobe", strobes - s0, 0);
        check("midrst_residue_cleared", out_residue, 32'd0);
        send_frame(tv[1].frame, tv[1].len, tv[1].len, 1'b0, fw, bm);
        wait_verdict(lat);
        check("after_rst_latency", lat, 9);
        check("after_rst_crc_ok",  {31'b0, out_crc_ok}, 32'd1);
        check("after_rst_residue", out_residue, 32'd0);

        // Back-to-back frames with in_valid held high throughout
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        s0 = strobes;
        o0 = ok_strobes;
        send_frame(tv[0].frame, tv[0].len, tv[0].len, 1'b1, fw, bm);
        check("b2b_first_stall", bm, 0);
        check("b2b_in_ready_low", {31'b0, in_ready}, 32'd0);
        send_frame(tv[3].frame, tv[3].len, tv[3].len, 1'b0, fw, bm);
        check("b2b_check_stall", fw, 9);
        check("b2b_second_stall", bm, 0);
        repeat (30) @(posedge clk);
        #1;
        check("b2b_strobes", strobes - s0, 2);
        check("b2b_ok_strobes", ok_strobes - o0, 2);
`ifdef CRC_CHK_STATS_EN
        check("b2b_good_cnt", {16'b0, good_cnt}, 32'd2);
        check("b2b_bad_cnt",  {16'b0, bad_cnt},  32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
